senha_game_ctrl: RTL and testbench

Clocked controller that sequences the three-level switch-password guessing game on the board. It registers the 7-bit switch guess on each `enter` press and scores it bit-serially against the current level's password. The match count is shown as a thermometer on `LEDR`. The block tracks level progression and remaining attempts, and latches into a win or lockout state.

---
 rtl/senha_game_ctrl.sv | 136 +++++++++++++
 tb/tb_senha_game_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/senha_game_ctrl.sv
// Three-level password guessing game controller.
// A guess is captured on a synchronised enter press, scored one bit per
// clock against the current level's password, then judged. The match
// count drives LEDR as a thermometer. Win and lockout are terminal states
// that only reset leaves.
module senha_game_ctrl #(
  parameter logic [6:0] SENHA1    = 7'b0000000,
  parameter logic [6:0] SENHA2    = 7'b0000001,
  parameter logic [6:0] SENHA3    = 7'b1010101,
  parameter int         MAX_TRIES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] SW,
  input  logic       enter,
  output logic [6:0] LEDR,
  output logic [1:0] level,
  output logic [2:0] tries_left,
  output logic       busy,
  output logic       win,
  output logic       locked
);

  typedef enum logic [2:0] {WAIT, SCAN, JUDGE, WIN, LOCK} state_t;

  localparam logic [2:0] MAX_T = 3'(MAX_TRIES);

  state_t     state_q, next_state;
  logic       enter_s1, enter_s2, enter_s3;
  logic       enter_pulse;
  logic [6:0] sw_q;
  logic [2:0] cnt;
  logic [2:0] idx;
  logic [6:0] target;

  // Low n bits set: 0 -> 7'b0000000, 7 -> 7'b1111111.
  function automatic logic [6:0] therm(input logic [2:0] n);
    logic [6:0] t;
    t = '0;
    for (int i = 0; i < 7; i++)
      if (3'(i) < n) t[i] = 1'b1;
    return t;
  endfunction

  // Two-flop synchroniser plus one extra flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_s1 <= 1'b0;
      enter_s2 <= 1'b0;
      enter_s3 <= 1'b0;
    end else begin
      enter_s1 <= enter;
      enter_s2 <= enter_s1;
      enter_s3 <= enter_s2;
    end
  end

  assign enter_pulse = enter_s2 & ~enter_s3;

  // Password for the level being played; level 3 only occurs in WIN.
  always_comb begin
    target = SENHA3;
    case (level)
      2'd0:    target = SENHA1;
      2'd1:    target = SENHA2;
      default: target = SENHA3;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT;
    else        state_q <= next_state;
  end

  // Next-state logic; presses outside WAIT are simply dropped.
  always_comb begin
    next_state = state_q;
    case (state_q)
      WAIT:    if (enter_pulse) next_state = SCAN;
      SCAN:    if (idx == 3'd6) next_state = JUDGE;
      JUDGE: begin
        if (cnt == 3'd7) next_state = (level == 2'd2) ? WIN : WAIT;
        else             next_state = (tries_left == 3'd1) ? LOCK : WAIT;
      end
      WIN:     next_state = WIN;
      LOCK:    next_state = LOCK;
      default: next_state = WAIT;
    endcase
  end

  // Capture, bit-serial scoring, judgement and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q       <= '0;
      cnt        <= '0;
      idx        <= '0;
      LEDR       <= '0;
      level      <= '0;
      tries_left <= MAX_T;
      busy       <= 1'b0;
      win        <= 1'b0;
      locked     <= 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          if (enter_pulse) begin
            sw_q <= SW;
            cnt  <= '0;
            idx  <= '0;
          end
        end
        SCAN: begin
          if (sw_q[idx] == target[idx]) cnt <= cnt + 3'd1;
          idx <= idx + 3'd1;
        end
        JUDGE: begin
          LEDR <= (next_state == LOCK) ? 7'b0000000 : therm(cnt);
          if (cnt == 3'd7) begin
            tries_left <= MAX_T;
            level      <= level + 2'd1;
          end else begin
            tries_left <= tries_left - 3'd1;
          end
        end
        WIN:  LEDR <= 7'b1111111;
        LOCK: LEDR <= 7'b0000000;
        default: ;
      endcase
      busy   <= (next_state == SCAN) || (next_state == JUDGE);
      win    <= (next_state == WIN);
      locked <= (next_state == LOCK);
    end
  end

endmodule

// File: tb/tb_senha_game_ctrl.sv
// Directed bench for the password game controller.
module tb_senha_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] SW = '0;
  logic       enter = 1'b0;
  logic [6:0] LEDR;
  logic [1:0] level;
  logic [2:0] tries_left;
  logic       busy, win, locked;

  int vectors = 0;
  int errors  = 0;

  senha_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .SW(SW), .enter(enter), .LEDR(LEDR),
    .level(level), .tries_left(tries_left), .busy(busy), .win(win),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [6:0] e_ledr, input logic [1:0] e_lvl,
                          input logic [2:0] e_tries, input logic e_win, input logic e_lock);
    chk({tag, ".LEDR"}, 32'(LEDR), 32'(e_ledr));
    chk({tag, ".level"}, 32'(level), 32'(e_lvl));
    chk({tag, ".tries"}, 32'(tries_left), 32'(e_tries));
    chk({tag, ".win"}, 32'(win), 32'(e_win));
    chk({tag, ".locked"}, 32'(locked), 32'(e_lock));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    SW    = '0;
    enter = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full guess: press, wait for busy, count busy cycles, release.
  task automatic guess(input string tag, input logic [6:0] sw, output int bcnt);
    int t;
    SW    = sw;
    enter = 1'b1;
    t     = 0;
    bcnt  = 0;
    while (!busy && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!busy) chk({tag, ".busy_timeout"}, 32'd0, 32'd1);
    while (busy && bcnt < 20) begin
      @(negedge clk);
      bcnt++;
    end
    enter = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Press that must be ignored: busy must never rise.
  task automatic ignored_press(input string tag, input logic [6:0] sw);
    int seen;
    seen  = 0;
    SW    = sw;
    enter = 1'b1;
    repeat (14) begin
      @(negedge clk);
      if (busy) seen++;
    end
    enter = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk({tag, ".busy_cycles"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int bc;
    int seen;

    // Reset state
    do_reset();
    chk_outs("reset", 7'h00, 2'd0, 3'd4, 1'b0, 1'b0);

    // Level-0 pass, then partial match at level 1
    guess("l0pass", 7'b0000000, bc);
    chk("l0pass.busy_len", 32'(bc), 32'd8);
    chk_outs("l0pass", 7'b1111111, 2'd1, 3'd4, 1'b0, 1'b0);
    guess("partial", 7'b1000000, bc);
    chk_outs("partial", 7'b0011111, 2'd1, 3'd3, 1'b0, 1'b0);

    // Lockout at level 0
    do_reset();
    guess("lock1", 7'b1111111, bc);
    chk_outs("lock1", 7'h00, 2'd0, 3'd3, 1'b0, 1'b0);
    guess("lock2", 7'b1111111, bc);
    chk_outs("lock2", 7'h00, 2'd0, 3'd2, 1'b0, 1'b0);
    guess("lock3", 7'b1111111, bc);
    chk_outs("lock3", 7'h00, 2'd0, 3'd1, 1'b0, 1'b0);
    guess("lock4", 7'b1111111, bc);
    chk_outs("lock4", 7'h00, 2'd0, 3'd0, 1'b0, 1'b1);
    ignored_press("lock5", 7'b0000000);
    chk_outs("lock5", 7'h00, 2'd0, 3'd0, 1'b0, 1'b1);

    // Partial guess that exhausts tries must still show LEDR=0
    do_reset();
    repeat (3) guess("lockp", 7'b0000001, bc);
    chk_outs("lockp3", 7'b0111111, 2'd0, 3'd1, 1'b0, 1'b0);
    guess("lockp4", 7'b0000001, bc);
    chk_outs("lockp4", 7'h00, 2'd0, 3'd0, 1'b0, 1'b1);

    // Full solve
    do_reset();
    guess("solve1", 7'b0000000, bc);
    chk_outs("solve1", 7'b1111111, 2'd1, 3'd4, 1'b0, 1'b0);
    guess("solve2", 7'b0000001, bc);
    chk_outs("solve2", 7'b1111111, 2'd2, 3'd4, 1'b0, 1'b0);
    guess("solve3w", 7'b1010100, bc);
    chk_outs("solve3w", 7'b0111111, 2'd2, 3'd3, 1'b0, 1'b0);
    guess("solve3", 7'b1010101, bc);
    chk_outs("solve3", 7'b1111111, 2'd3, 3'd4, 1'b1, 1'b0);
    ignored_press("win_press", 7'b0000000);
    chk_outs("win_press", 7'b1111111, 2'd3, 3'd4, 1'b1, 1'b0);

    // Busy-window robustness: second press and SW change during scoring
    do_reset();
    SW    = 7'b0000000;
    enter = 1'b1;
    seen  = 0;
    while (!busy && seen < 10) begin
      @(negedge clk);
      seen++;
    end
    chk("bw.busy_rise", 32'(busy), 32'd1);
    SW    = 7'b1111111;
    enter = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enter = 1'b1;
    seen  = 0;
    while (busy && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk_outs("bw.judge", 7'b1111111, 2'd1, 3'd4, 1'b0, 1'b0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("bw.extra_busy", 32'(seen), 32'd0);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs("bw.after", 7'b1111111, 2'd1, 3'd4, 1'b0, 1'b0);

    // Reset asserted mid-SCAN: outputs clear before any clock edge
    do_reset();
    guess("pre", 7'b1111111, bc);
    chk_outs("pre", 7'h00, 2'd0, 3'd3, 1'b0, 1'b0);
    SW    = 7'b0000000;
    enter = 1'b1;
    seen  = 0;
    while (!busy && seen < 10) begin
      @(negedge clk);
      seen++;
    end
    chk("mid.busy_rise", 32'(busy), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_outs("mid.async", 7'h00, 2'd0, 3'd4, 1'b0, 1'b0);
    enter = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_outs("mid.post", 7'h00, 2'd0, 3'd4, 1'b0, 1'b0);
    guess("mid.guess", 7'b0000000, bc);
    chk("mid.busy_len", 32'(bc), 32'd8);
    chk_outs("mid.guess", 7'b1111111, 2'd1, 3'd4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
